elbeth_id_ex_stage: RTL and testbench
=====================================

Name: elbeth_id_ex_stage

Overview:
ID/EX pipeline register of the ELBETH core; its registered exs_* control outputs feed the hazard/forwarding unit.
- Consumes the forwarding-unit matches to select bypassed operands at capture.
- Detects load-use hazards, inserts one-cycle bubbles and holds ID.
- Honours downstream stall and branch flush.

Parameters:
XLEN, 32, datapath/operand/PC width
ALU_OP_W, 4, width of ALU operation code

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high
exs_stall  input  1  downstream stall; hold all EX registers
flush  input  1  branch/jump redirect; kill instruction entering EX
id_valid  input  1  ID holds a valid instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1  input  5  source register 1 address
id_rs2  input  5  source register 2 address
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rs1_data  input  XLEN  register-file read data 1
id_rs2_data  input  XLEN  register-file read data 2
id_imm  input  XLEN  decoded immediate
id_alu_op  input  ALU_OP_W  ALU operation
id_rd_addr  input  5  destination register
id_w_gpr_en  input  1  writes GPR
id_mem_en  input  1  memory access
id_mem_wr  input  1  memory write (store)
match_forward_rs1  input  1  bypass needed for rs1
match_forward_rs2  input  1  bypass needed for rs2
forward_from  input  1  bypass source: 0 = EX ALU result, 1 = MEM writeback data
fwd_alu_data  input  XLEN  EX ALU result
fwd_mem_data  input  XLEN  MEM writeback data
id_hold  output  1  stall IF/ID (combinational)
exs_valid  output  1  EX holds a valid instruction
exs_pc  output  XLEN  registered PC
exs_rs1_data  output  XLEN  registered operand 1, post-forwarding
exs_rs2_data  output  XLEN  registered operand 2, post-forwarding
exs_imm  output  XLEN  registered immediate
exs_alu_op  output  ALU_OP_W  registered ALU op
exs_rd_addr  output  5  registered rd
exs_w_gpr_en  output  1  registered GPR write enable
exs_mem_en  output  1  registered memory enable
exs_mem_wr  output  1  registered memory write

Behaviour:
- Reset: all exs_* outputs are 0 (exs_valid=0, data fields 0). id_hold is 0 while rst=1.
- load_use = exs_valid & exs_mem_en & ~exs_mem_wr & exs_w_gpr_en & (exs_rd_addr != 0) & ((id_rs1_used & id_rs1 == exs_rd_addr) | (id_rs2_used & id_rs2 == exs_rd_addr)).
- id_hold = exs_stall | (load_use & id_valid & ~flush).
- Register update priority on each rising clk:
  - rst: clear everything.
  - flush: load a bubble, even if exs_stall is asserted.
  - exs_stall: hold all registers unchanged.
  - load_use & id_valid: load a bubble. ID is held, so the same instruction re-evaluates next cycle. Exactly one bubble per load.
  - Otherwise: capture all id_* fields. exs_valid = id_valid.
- Bubble: exs_valid, exs_w_gpr_en, exs_mem_en and exs_mem_wr are 0. exs_rd_addr is 0. Data fields are 0.
- Operand select at capture, per operand: if match_forward_rsN then (forward_from ? fwd_mem_data : fwd_alu_data), else id_rsN_data. Applies identically to rs1 and rs2.
- Operands are sampled only on capture cycles; held values never re-select.
- Latency: one cycle ID to EX. Throughput: one per cycle absent hazards.
- x0 is never a load-use source (rd=0 check above).
- An invalid ID instruction (id_valid=0) never raises load_use-driven hold. It is captured as exs_valid=0 with control fields forced to 0.

Optional Feature:
ELBETH_ID_EX_PERF_EN
- Defined: adds outputs perf_bubbles[31:0] and perf_flushes[31:0], both reset to 0 and wrapping at 2^32.
  - perf_bubbles increments on every load-use bubble cycle.
  - perf_flushes increments on every cycle flush=1 (not rst).
- Undefined: ports and counters are absent; remaining behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles with id_valid=1 -> all exs_* 0, id_hold 0. Release -> id_pc=0x100 appears on exs_pc the next cycle with exs_valid=1.
2. EX holds a load (mem_en=1, mem_wr=0, rd=5). ID has rs1=5 with id_rs1_used=1 -> id_hold=1 for one cycle and a bubble enters EX (exs_valid=0). The next cycle the instruction is captured and id_hold=0.
3. match_forward_rs2=1, forward_from=0, fwd_alu_data=0xDEADBEEF, id_rs2_data=0x1 -> exs_rs2_data=0xDEADBEEF. Repeat with forward_from=1 and fwd_mem_data=0x55 -> 0x55.
4. exs_stall=1 for 3 cycles while ID inputs change -> exs_* unchanged and id_hold=1. Release -> the current ID is captured.
5. flush=1 together with exs_stall=1 and a load-use condition -> bubble loaded, id_hold equals exs_stall (1).
6. Load with rd=0 followed by a consumer of x0 -> no hold, no bubble. With ELBETH_ID_EX_PERF_EN, scenarios 2+5 give perf_bubbles=1 and perf_flushes=1.

Source files
------------

// File: rtl/elbeth_id_ex_stage.sv
// ELBETH ID/EX pipeline register: operand bypass select, load-use bubble insertion, stall/flush.
// Optional ELBETH_ID_EX_PERF_EN adds bubble/flush performance counters.
module elbeth_id_ex_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                exs_stall,
   input  logic                flush,
   input  logic                id_valid,
   input  logic [XLEN-1:0]     id_pc,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   input  logic                id_rs1_used,
   input  logic                id_rs2_used,
   input  logic [XLEN-1:0]     id_rs1_data,
   input  logic [XLEN-1:0]     id_rs2_data,
   input  logic [XLEN-1:0]     id_imm,
   input  logic [ALU_OP_W-1:0] id_alu_op,
   input  logic [4:0]          id_rd_addr,
   input  logic                id_w_gpr_en,
   input  logic                id_mem_en,
   input  logic                id_mem_wr,
   input  logic                match_forward_rs1,
   input  logic                match_forward_rs2,
   input  logic                forward_from,
   input  logic [XLEN-1:0]     fwd_alu_data,
   input  logic [XLEN-1:0]     fwd_mem_data,
   output logic                id_hold,
   output logic                exs_valid,
   output logic [XLEN-1:0]     exs_pc,
   output logic [XLEN-1:0]     exs_rs1_data,
   output logic [XLEN-1:0]     exs_rs2_data,
   output logic [XLEN-1:0]     exs_imm,
   output logic [ALU_OP_W-1:0] exs_alu_op,
   output logic [4:0]          exs_rd_addr,
   output logic                exs_w_gpr_en,
   output logic                exs_mem_en,
   output logic                exs_mem_wr
`ifdef ELBETH_ID_EX_PERF_EN
   ,
   output logic [31:0]         perf_bubbles,
   output logic [31:0]         perf_flushes
`endif
);

   logic            load_use;
   logic            lu_bubble;
   logic            kill;
   logic [XLEN-1:0] fwd_data;
   logic [XLEN-1:0] op1_sel;
   logic [XLEN-1:0] op2_sel;

   // A load in EX whose destination is read by the ID instruction; x0 never counts.
   always_comb begin
      load_use = 1'b0;
      if (exs_valid && exs_mem_en && !exs_mem_wr && exs_w_gpr_en && (exs_rd_addr != 5'd0)) begin
         load_use = (id_rs1_used && (id_rs1 == exs_rd_addr)) ||
                    (id_rs2_used && (id_rs2 == exs_rd_addr));
      end
   end

   always_comb begin
      lu_bubble = load_use && id_valid && !flush && !exs_stall;
      kill      = flush || lu_bubble;
      id_hold   = !rst && (exs_stall || (load_use && id_valid && !flush));
   end

   // Bypass operand select, only consumed on capture cycles.
   always_comb begin
      fwd_data = forward_from ? fwd_mem_data : fwd_alu_data;
      op1_sel  = match_forward_rs1 ? fwd_data : id_rs1_data;
      op2_sel  = match_forward_rs2 ? fwd_data : id_rs2_data;
   end

   // Flush beats stall; a load-use bubble only loads when EX is free to advance.
   always_ff @(posedge clk) begin
      if (rst || kill) begin
         exs_valid    <= 1'b0;
         exs_pc       <= '0;
         exs_rs1_data <= '0;
         exs_rs2_data <= '0;
         exs_imm      <= '0;
         exs_alu_op   <= '0;
         exs_rd_addr  <= 5'd0;
         exs_w_gpr_en <= 1'b0;
         exs_mem_en   <= 1'b0;
         exs_mem_wr   <= 1'b0;
      end else if (!exs_stall) begin
         exs_valid    <= id_valid;
         exs_pc       <= id_pc;
         exs_rs1_data <= op1_sel;
         exs_rs2_data <= op2_sel;
         exs_imm      <= id_imm;
         exs_alu_op   <= id_alu_op;
         exs_rd_addr  <= id_valid ? id_rd_addr : 5'd0;
         exs_w_gpr_en <= id_valid && id_w_gpr_en;
         exs_mem_en   <= id_valid && id_mem_en;
         exs_mem_wr   <= id_valid && id_mem_wr;
      end
   end

`ifdef ELBETH_ID_EX_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubbles <= 32'd0;
         perf_flushes <= 32'd0;
      end else begin
         if (lu_bubble) perf_bubbles <= perf_bubbles + 32'd1;
         if (flush)     perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_elbeth_id_ex_stage.sv
// Directed bench for elbeth_id_ex_stage: vector table for capture/bypass, hand sequences for hazards.
module tb_elbeth_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        exs_stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, fwd_alu_data, fwd_mem_data;
   logic [4:0]  id_rs1, id_rs2, id_rd_addr;
   logic        id_rs1_used, id_rs2_used, id_w_gpr_en, id_mem_en, id_mem_wr;
   logic [3:0]  id_alu_op;
   logic        match_forward_rs1, match_forward_rs2, forward_from;
   logic        id_hold, exs_valid, exs_w_gpr_en, exs_mem_en, exs_mem_wr;
   logic [31:0] exs_pc, exs_rs1_data, exs_rs2_data, exs_imm;
   logic [3:0]  exs_alu_op;
   logic [4:0]  exs_rd_addr;
`ifdef ELBETH_ID_EX_PERF_EN
   logic [31:0] perf_bubbles, perf_flushes;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   elbeth_id_ex_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
      .clk(clk), .rst(rst), .exs_stall(exs_stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_rd_addr(id_rd_addr),
      .id_w_gpr_en(id_w_gpr_en), .id_mem_en(id_mem_en), .id_mem_wr(id_mem_wr),
      .match_forward_rs1(match_forward_rs1), .match_forward_rs2(match_forward_rs2),
      .forward_from(forward_from), .fwd_alu_data(fwd_alu_data), .fwd_mem_data(fwd_mem_data),
      .id_hold(id_hold), .exs_valid(exs_valid), .exs_pc(exs_pc), .exs_rs1_data(exs_rs1_data),
      .exs_rs2_data(exs_rs2_data), .exs_imm(exs_imm), .exs_alu_op(exs_alu_op),
      .exs_rd_addr(exs_rd_addr), .exs_w_gpr_en(exs_w_gpr_en), .exs_mem_en(exs_mem_en),
      .exs_mem_wr(exs_mem_wr)
`ifdef ELBETH_ID_EX_PERF_EN
      , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc, d1, d2;
      logic        mf1, mf2, from;
      logic [31:0] alu, mem;
      logic [4:0]  rd;
      logic        w, me, mw;
      logic        ev;
      logic [31:0] e1, e2;
      logic [4:0]  erd;
      logic        ew, eme, emw;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exs_stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = 32'd0;
      id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_alu_op = 4'd0;
      id_rd_addr = 5'd0; id_w_gpr_en = 1'b0; id_mem_en = 1'b0; id_mem_wr = 1'b0;
      match_forward_rs1 = 1'b0; match_forward_rs2 = 1'b0; forward_from = 1'b0;
      fwd_alu_data = 32'd0; fwd_mem_data = 32'd0;
   endtask

   task automatic load_in_ex(input logic [4:0] rd);
      idle();
      id_valid = 1'b1; id_pc = 32'h0000_0F00; id_rd_addr = rd;
      id_w_gpr_en = 1'b1; id_mem_en = 1'b1;
      tick();
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h100, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 32'hAAAA, 32'hBBBB,
                  5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 5'd3, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h104, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h55,
                  5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1, 32'hDEADBEEF, 5'd4, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h108, 32'h1, 32'h1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h55,
                  5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1, 32'h55, 5'd4, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h10C, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0, 32'h77, 32'h88,
                  5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'h77, 5'd8, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h110, 32'h3, 32'h99, 1'b1, 1'b0, 1'b1, 32'h77, 32'h88,
                  5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 32'h88, 32'h99, 5'd9, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 32'h114, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                  5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5, 32'h6, 5'd0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 32'h118, 32'h40, 32'h41, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                  5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h41, 5'd0, 1'b0, 1'b1, 1'b1};

      // Reset with a valid instruction waiting in ID.
      idle();
      rst = 1'b1; id_valid = 1'b1; id_pc = 32'h100; id_w_gpr_en = 1'b1; id_rd_addr = 5'd3;
      tick();
      exs_stall = 1'b1;
      tick();
      chk("rst_valid", 32'(exs_valid), 32'd0);
      chk("rst_pc", exs_pc, 32'd0);
      chk("rst_rs1", exs_rs1_data, 32'd0);
      chk("rst_rd", 32'(exs_rd_addr), 32'd0);
      chk("rst_wgpr", 32'(exs_w_gpr_en), 32'd0);
      chk("rst_hold", 32'(id_hold), 32'd0);
      exs_stall = 1'b0;
      rst = 1'b0;

      // Capture and bypass vectors; the first one is the post-reset 0x100 instruction.
      for (int i = 0; i < 7; i++) begin
         id_valid = vecs[i].valid; id_pc = vecs[i].pc;
         id_rs1_data = vecs[i].d1; id_rs2_data = vecs[i].d2;
         id_imm = vecs[i].pc ^ 32'h5A5A_0000; id_alu_op = 4'(vecs[i].pc >> 2);
         match_forward_rs1 = vecs[i].mf1; match_forward_rs2 = vecs[i].mf2;
         forward_from = vecs[i].from; fwd_alu_data = vecs[i].alu; fwd_mem_data = vecs[i].mem;
         id_rd_addr = vecs[i].rd; id_w_gpr_en = vecs[i].w;
         id_mem_en = vecs[i].me; id_mem_wr = vecs[i].mw;
         tick();
         chk($sformatf("v%0d_valid", i), 32'(exs_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d_pc", i), exs_pc, vecs[i].pc);
         chk($sformatf("v%0d_imm", i), exs_imm, vecs[i].pc ^ 32'h5A5A_0000);
         chk($sformatf("v%0d_op", i), 32'(exs_alu_op), 32'(4'(vecs[i].pc >> 2)));
         chk($sformatf("v%0d_rs1", i), exs_rs1_data, vecs[i].e1);
         chk($sformatf("v%0d_rs2", i), exs_rs2_data, vecs[i].e2);
         chk($sformatf("v%0d_rd", i), 32'(exs_rd_addr), 32'(vecs[i].erd));
         chk($sformatf("v%0d_wgpr", i), 32'(exs_w_gpr_en), 32'(vecs[i].ew));
         chk($sformatf("v%0d_memen", i), 32'(exs_mem_en), 32'(vecs[i].eme));
         chk($sformatf("v%0d_memwr", i), 32'(exs_mem_wr), 32'(vecs[i].emw));
         chk($sformatf("v%0d_hold", i), 32'(id_hold), 32'd0);
      end

      // Load-use on rs1: one bubble, then the consumer is captured.
      load_in_ex(5'd5);
      idle();
      id_valid = 1'b1; id_pc = 32'h200; id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs1_data = 32'h1234;
      #1;
      chk("lu_hold", 32'(id_hold), 32'd1);
      tick();
      chk("lu_bubble_valid", 32'(exs_valid), 32'd0);
      chk("lu_bubble_rd", 32'(exs_rd_addr), 32'd0);
      chk("lu_bubble_pc", exs_pc, 32'd0);
      chk("lu_release_hold", 32'(id_hold), 32'd0);
      tick();
      chk("lu_cap_valid", 32'(exs_valid), 32'd1);
      chk("lu_cap_pc", exs_pc, 32'h200);
      chk("lu_cap_rs1", exs_rs1_data, 32'h1234);

      // rs2 hazard detection, unused source and invalid ID never hold.
      load_in_ex(5'd6);
      idle();
      id_valid = 1'b1; id_pc = 32'h240; id_rs1 = 5'd6; id_rs2 = 5'd6; id_rs2_used = 1'b1;
      #1;
      chk("lu_rs2_hold", 32'(id_hold), 32'd1);
      id_rs2_used = 1'b0;
      #1;
      chk("lu_unused_hold", 32'(id_hold), 32'd0);
      id_rs2_used = 1'b1; id_valid = 1'b0;
      #1;
      chk("lu_invalid_hold", 32'(id_hold), 32'd0);
      tick();
      chk("lu_invalid_cap", 32'(exs_valid), 32'd0);
      chk("lu_invalid_pc", exs_pc, 32'h240);

      // x0 destination is never a load-use source.
      load_in_ex(5'd0);
      idle();
      id_valid = 1'b1; id_pc = 32'h300; id_rs1 = 5'd0; id_rs1_used = 1'b1;
      #1;
      chk("x0_hold", 32'(id_hold), 32'd0);
      tick();
      chk("x0_valid", 32'(exs_valid), 32'd1);
      chk("x0_pc", exs_pc, 32'h300);

      // Downstream stall holds EX; held operands do not re-select bypass data.
      idle();
      id_valid = 1'b1; id_pc = 32'h400; id_rs1_data = 32'hAA;
      tick();
      for (int k = 0; k < 3; k++) begin
         exs_stall = 1'b1; id_pc = 32'h500 + 32'(k * 4); id_rs1_data = 32'(k);
         match_forward_rs1 = 1'b1; fwd_alu_data = 32'(100 + k);
         tick();
         chk($sformatf("stall%0d_pc", k), exs_pc, 32'h400);
         chk($sformatf("stall%0d_rs1", k), exs_rs1_data, 32'hAA);
         chk($sformatf("stall%0d_hold", k), 32'(id_hold), 32'd1);
      end
      exs_stall = 1'b0;
      tick();
      chk("unstall_pc", exs_pc, 32'h508);
      chk("unstall_rs1", exs_rs1_data, 32'd102);

      // Flush with stall and a load-use hazard loads a bubble.
      load_in_ex(5'd9);
      idle();
      id_valid = 1'b1; id_pc = 32'h600; id_rs1 = 5'd9; id_rs1_used = 1'b1;
      exs_stall = 1'b1; flush = 1'b1;
      #1;
      chk("flush_hold", 32'(id_hold), 32'd1);
      tick();
      chk("flush_valid", 32'(exs_valid), 32'd0);
      chk("flush_memen", 32'(exs_mem_en), 32'd0);
      chk("flush_pc", exs_pc, 32'd0);
      exs_stall = 1'b0; flush = 1'b0;
      #1;
      chk("flush_after_hold", 32'(id_hold), 32'd0);
      tick();
      chk("flush_after_pc", exs_pc, 32'h600);

`ifdef ELBETH_ID_EX_PERF_EN
      chk("perf_bubbles", perf_bubbles, 32'd1);
      chk("perf_flushes", perf_flushes, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
